// File: rtl/signed_unsigned_4x4_bit_multiplier_if.sv
// Tile pin bundle for the 4x4 multiplier: enable, operands, mode/bidir pins and product.
// master = tile harness (drives ena/ui_in/uio_in), slave = multiplier (drives uo_out/uio_*).
// Ports: ena, ui_in[7:0], uio_in[7:0] toward the block; uo_out, uio_out, uio_oe from it.
interface signed_unsigned_4x4_bit_multiplier_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena,
    output ui_in,
    output uio_in,
    input  uo_out,
    input  uio_out,
    input  uio_oe
  );

  modport slave (
    input  ena,
    input  ui_in,
    input  uio_in,
    output uo_out,
    output uio_out,
    output uio_oe
  );
endinterface

// File: rtl/signed_unsigned_4x4_bit_multiplier.sv
// Purpose: 4x4 array multiplier, unsigned or two's-complement (Baugh-Wooley), registered 8-bit product.
// Latency: 1 cycle from ui_in/MODE to uo_out; one product per enabled cycle. No backpressure; ena=0 holds.
// Ports: clk, rst_n (async, active-HIGH despite the name), bus.slave: ena, ui_in={B,A},
//        uio_in[0]=MODE, uo_out=product, uio_out/uio_oe tied to 0 (all bidir pins are inputs).
module signed_unsigned_4x4_bit_multiplier (
  input  logic                                 clk,
  input  logic                                 rst_n,
  signed_unsigned_4x4_bit_multiplier_if.slave  bus
);

  logic [3:0]      op_a;
  logic [3:0]      op_b;
  logic            mode;
  logic [4:0][7:0] rows;      // rows 0..3: shifted partial products, row 4: correction constant
  logic [7:0]      sum;
  logic [7:0]      product_d;
  logic [7:0]      product_q;
  logic            unused_uio;

  assign op_a       = bus.ui_in[3:0];
  assign op_b       = bus.ui_in[7:4];
  assign mode       = bus.uio_in[0];
  assign unused_uio = &{1'b0, bus.uio_in[7:1]};

  // Returns {carry, sum}; with one input tied low it degenerates to a half adder.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic cin);
    logic s;
    logic c;
    s = x ^ y ^ cin;
    c = (x & y) | (cin & (x ^ y));
    return {c, s};
  endfunction

  always_comb begin
    logic       carry;
    logic [1:0] fa;
    rows  = '0;
    sum   = '0;
    carry = 1'b0;
    fa    = '0;

    // Partial product a[i]&b[j] at weight i+j, placed in row j.
    // Baugh-Wooley: terms pairing exactly one sign bit carry negative weight,
    // so they are inverted in signed mode; a3&b3 is positive and untouched.
    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < 4; i++) begin
        rows[j][i+j] = (op_a[i] & op_b[j]) ^ (mode & ((i == 3) != (j == 3)));
      end
    end

    // Correction constant 2^4 + 2^7 compensates the inversions (modulo 2^8).
    rows[4][4] = mode;
    rows[4][7] = mode;

    // Ripple-carry reduction, one row at a time; carries beyond bit 7 are
    // dropped since the product is exact within 8 bits in both modes.
    sum = rows[0];
    for (int r = 1; r < 5; r++) begin
      carry = 1'b0;
      for (int k = 0; k < 8; k++) begin
        fa     = full_add(sum[k], rows[r][k], carry);
        sum[k] = fa[0];
        carry  = fa[1];
      end
    end

    product_d = bus.ena ? sum : product_q;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      product_q <= 8'h00;
    end else begin
      product_q <= product_d;
    end
  end

  assign bus.uo_out  = product_q;
  assign bus.uio_out = 8'h00;
  assign bus.uio_oe  = 8'h00;

endmodule

// File: tb/tb_signed_unsigned_4x4_bit_multiplier.sv
// Self-checking bench for signed_unsigned_4x4_bit_multiplier: directed cases,
// mode toggle, enable hold, async reset, exhaustive sweep and random vectors.
module tb_signed_unsigned_4x4_bit_multiplier;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  logic [7:0] model_q;

  always #5 clk = ~clk;

  signed_unsigned_4x4_bit_multiplier_if bus ();

  signed_unsigned_4x4_bit_multiplier dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [7:0] ref_prod(input logic [7:0] ui, input logic mode);
    int a;
    int b;
    int p;
    a = int'(ui[3:0]);
    b = int'(ui[7:4]);
    if (mode) begin
      if (a > 7) a -= 16;
      if (b > 7) b -= 16;
    end
    p = a * b;
    return 8'(p);
  endfunction

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs (upper uio_in bits randomized, must be ignored),
  // take a rising edge, update the model, and leave time at edge+1.
  task automatic tick(input logic [7:0] ui, input logic mode, input logic en);
    bus.ui_in  = ui;
    bus.uio_in = {7'($urandom), mode};
    bus.ena    = en;
    @(posedge clk);
    if (rst_n) model_q = 8'h00;
    else if (en) model_q = ref_prod(ui, mode);
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    bus.ena    = 1'b1;
    bus.ui_in  = 8'hFF;
    bus.uio_in = 8'h00;
    model_q    = 8'h00;

    // Async reset, effective before any clock edge.
    #1 rst_n = 1'b1;
    #1;
    check_eq("rst_async", bus.uo_out, 8'h00);
    check_eq("rst_uio_out", bus.uio_out, 8'h00);
    check_eq("rst_uio_oe", bus.uio_oe, 8'h00);
    tick(8'hFF, 1'b0, 1'b1);
    check_eq("rst_hold1", bus.uo_out, 8'h00);
    tick(8'hFF, 1'b1, 1'b1);
    check_eq("rst_hold2", bus.uo_out, 8'h00);
    rst_n = 1'b0;

    // Directed unsigned / signed products.
    tick(8'h53, 1'b0, 1'b1); check_eq("u_3x5", bus.uo_out, 8'h0F);
    tick(8'hFF, 1'b0, 1'b1); check_eq("u_15x15", bus.uo_out, 8'hE1);
    tick(8'h90, 1'b0, 1'b1); check_eq("u_0x9", bus.uo_out, 8'h00);
    tick(8'h7F, 1'b1, 1'b1); check_eq("s_m1x7", bus.uo_out, 8'hF9);
    tick(8'h88, 1'b1, 1'b1); check_eq("s_m8xm8", bus.uo_out, 8'h40);
    tick(8'hFF, 1'b1, 1'b1); check_eq("s_m1xm1", bus.uo_out, 8'h01);
    tick(8'h87, 1'b1, 1'b1); check_eq("s_7xm8", bus.uo_out, 8'hC8);

    // Mode toggle with operands held.
    tick(8'hFF, 1'b0, 1'b1); check_eq("toggle_u", bus.uo_out, 8'hE1);
    tick(8'hFF, 1'b1, 1'b1); check_eq("toggle_s", bus.uo_out, 8'h01);

    // Enable hold.
    tick(8'h53, 1'b0, 1'b1); check_eq("hold_load", bus.uo_out, 8'h0F);
    for (int i = 0; i < 3; i++) begin
      tick(8'hFF, 1'b0, 1'b0); check_eq("hold_ena0", bus.uo_out, 8'h0F);
    end
    tick(8'hFF, 1'b0, 1'b1); check_eq("hold_release", bus.uo_out, 8'hE1);

    // Reset mid-operation: asynchronous clear, held through an edge, then reload.
    tick(8'h87, 1'b1, 1'b1); check_eq("mid_load", bus.uo_out, 8'hC8);
    #2 rst_n = 1'b1;
    #1 check_eq("mid_rst_async", bus.uo_out, 8'h00);
    model_q = 8'h00;
    tick(8'hFF, 1'b1, 1'b1); check_eq("mid_rst_held", bus.uo_out, 8'h00);
    rst_n = 1'b0;
    tick(8'h7F, 1'b1, 1'b1); check_eq("mid_reload", bus.uo_out, 8'hF9);

    // Exhaustive sweep of both modes against the arithmetic model.
    for (int m = 0; m < 2; m++) begin
      for (int v = 0; v < 256; v++) begin
        tick(8'(v), 1'(m), 1'b1);
        check_eq(m ? "exh_signed" : "exh_unsigned", bus.uo_out, model_q);
      end
    end

    // Random operands, mode and enable (enable mostly high).
    for (int n = 0; n < 400; n++) begin
      tick(8'($urandom), 1'($urandom), ($urandom_range(3, 0) != 0));
      check_eq("random", bus.uo_out, model_q);
      if (n % 100 == 0) begin
        check_eq("rand_uio_oe", bus.uio_oe, 8'h00);
        check_eq("rand_uio_out", bus.uio_out, 8'h00);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
